timer_bank: RTL
===============

Name: timer_bank

Overview:
- Parametrised bank of NUM_CH independent PLC-style timers sharing one prescaled timebase.
- Four modes per channel: on-delay (TON), true off-delay (TOF), retentive on-delay (RTO) and one-shot pulse (TP).
- Per-channel synchronous clear and runtime mode select.
- Sits in the peripheral area beside the counters and serves timer instructions from the IL pipeline.

Parameters:
- NUM_CH, 4: number of timer channels.
- ACC_W, 8: accumulator and preset width, in bits.
- PRESCALE, 1: clk cycles per timebase tick. Must be ≥1.
- PRE_W, 8: prescaler counter width. Requires PRESCALE ≤ 2^PRE_W.

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel enable / timer input rung.
- clr  in  NUM_CH  per-channel synchronous clear.
- type  in  2*NUM_CH  per-channel mode: 00 TON, 01 TOF, 10 RTO, 11 TP. Channel i uses bits [2i+1:2i].
- preset  in  ACC_W*NUM_CH  per-channel preset, in ticks.
- DN  out  NUM_CH  done bit.
- TT  out  NUM_CH  timer-timing bit.
- ACC  out  ACC_W*NUM_CH  per-channel accumulator.
- tick  out  1  timebase tick strobe.

Behaviour:
- Reset (reset=0, asynchronous): ACC=0, DN=0, TT=0, tick=0, prescaler=0, latched mode=TON, en_d=0 for all channels.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is registered and is 1 for exactly one clk when the count wraps.
  - With PRESCALE=1, tick stays 1 continuously after reset is released.
  - The prescaler free-runs; neither en nor clr affects it.
- Accumulate rule, all modes: ACC_next = ACC+1 only when tick=1 and counting is permitted and ACC<preset. Otherwise ACC holds.
- ACC saturates at preset and never wraps.
- If preset is lowered below ACC, ACC holds its value (no clipping) and the channel is treated as done.
- Priority per channel, highest first:
  1. reset
  2. clr=1: ACC=0, DN=0, TT=0.
  3. type change: type differs from the latched mode → latch the new mode; ACC=0, DN=0, TT=0 for that cycle.
  4. Mode logic below.
- en_d is a registered copy of en. It is updated every cycle, including during clr.
- TON:
  - en=0 → ACC=0, DN=0, TT=0 on the next edge.
  - en=1 → count is permitted; DN_next = (ACC_next ≥ preset); TT_next = !DN_next.
- TOF:
  - en=1 → ACC=0, DN=1, TT=0.
  - en=0 → counting is permitted only while DN=1; DN_next = DN & (ACC_next < preset); TT_next = DN_next.
  - Out of reset with en=0: DN stays 0.
  - preset=0: DN drops on the first edge after en falls.
- RTO:
  - en=1 → count is permitted; TT_next = !DN_next.
  - en=0 → ACC holds, TT=0.
  - DN_next = (ACC_next ≥ preset) regardless of en.
  - Only clr, reset or a mode change clears ACC.
- TP:
  - A rising edge (en & !en_d) while TT=0 with preset>0 starts a pulse: ACC=0, DN=1, TT=1.
  - While TT=1, counting is permitted; when ACC_next ≥ preset, DN=0 and TT=0.
  - Rising edges of en while TT=1 are ignored (no retrigger).
  - A rising edge with preset=0 produces no pulse.
  - en falling mid-pulse does not stop the pulse.
- DN, TT and ACC are registered. Latency from a sampled input to the output is one clk.
- Channels are fully independent, and simultaneous events on different channels do not interact.
- Reset mid-count: all state clears immediately, asynchronously.

Test Plan:
- TON, PRESCALE=1, preset=5, en raised → ACC 1,2,3,4,5 on successive edges; TT=1 for the first 4 edges; DN=1, TT=0 from the 5th edge. Drop en → ACC=0, DN=0 next edge.
- TOF, preset=3:
  - en high → DN=1, ACC=0.
  - en low → TT=1, ACC counts 1,2,3.
  - DN and TT fall at ACC=3.
  - Re-raising en at ACC=1 → ACC=0, DN stays 1.
- RTO, preset=6: en high for 4 edges → ACC=4; en low for 10 edges → ACC=4, TT=0; en high 2 edges → ACC=6, DN=1; en low → DN stays 1; clr pulse → ACC=0, DN=0.
- TP, preset=4: en single-cycle pulse → DN=TT=1 for exactly 4 edges. Second en pulse at ACC=2 is ignored. Pulse with preset=0 → DN stays 0.
- PRESCALE=4, TON, preset=2: tick every 4th clk; DN asserts on the edge of the 2nd tick after en rises; ACC changes only on tick cycles.
- Multi-channel, NUM_CH=4:
  - ch0 TON, ch1 TOF, ch2 RTO, ch3 TP run concurrently with no cross-talk.
  - Changing the ch2 type mid-count clears ch2 only.
  - reset asserted mid-count clears all channels and the prescaler asynchronously, without waiting for clk.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH independent PLC-style timers sharing one prescaled
// timebase. Modes per channel: TON (00), TOF (01), RTO (10), TP (11).
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   en        per-channel enable / timer input rung
//   clr       per-channel synchronous clear
//   tmr_type  per-channel mode select, channel i uses bits [2i+1:2i]
//   preset    per-channel preset in ticks, channel i uses bits [ACC_W*i +: ACC_W]
//   DN        per-channel done bit
//   TT        per-channel timer-timing bit
//   ACC       per-channel accumulator
//   tick      timebase tick strobe
module timer_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PRE_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [2*NUM_CH-1:0]     tmr_type,
    input  logic [ACC_W*NUM_CH-1:0] preset,
    output logic [NUM_CH-1:0]       DN,
    output logic [NUM_CH-1:0]       TT,
    output logic [ACC_W*NUM_CH-1:0] ACC,
    output logic                    tick
);

    localparam logic [1:0] MODE_TON = 2'b00;
    localparam logic [1:0] MODE_TOF = 2'b01;
    localparam logic [1:0] MODE_RTO = 2'b10;
    localparam logic [1:0] MODE_TP  = 2'b11;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt;
    logic [NUM_CH-1:0] en_d;
    logic [1:0]        mode_q   [NUM_CH];
    logic [1:0]        mode_n   [NUM_CH];
    logic [1:0]        type_cur [NUM_CH];
    logic [ACC_W-1:0]  acc_cur  [NUM_CH];
    logic [ACC_W-1:0]  pre_cur  [NUM_CH];
    logic [ACC_W-1:0]  acc_step [NUM_CH];
    logic [ACC_W-1:0]  acc_n    [NUM_CH];
    logic [NUM_CH-1:0] dn_n;
    logic [NUM_CH-1:0] tt_n;

    // Free-running prescaler; tick is high for the clk following each wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
            tick    <= 1'b0;
        end
    end

    // Unpack per-channel fields and form the saturating increment candidate.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            acc_cur[i]  = ACC[i*ACC_W +: ACC_W];
            pre_cur[i]  = preset[i*ACC_W +: ACC_W];
            type_cur[i] = tmr_type[2*i +: 2];
            acc_step[i] = (tick && (acc_cur[i] < pre_cur[i])) ? acc_cur[i] + ACC_W'(1)
                                                               : acc_cur[i];
        end
    end

    // Per-channel next state: clear, then mode change, then mode behaviour.
    always_comb begin
        dn_n = DN;
        tt_n = TT;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            mode_n[i] = mode_q[i];
            acc_n[i]  = acc_cur[i];
            if (clr[i]) begin
                acc_n[i] = '0;
                dn_n[i]  = 1'b0;
                tt_n[i]  = 1'b0;
            end else if (type_cur[i] != mode_q[i]) begin
                mode_n[i] = type_cur[i];
                acc_n[i]  = '0;
                dn_n[i]   = 1'b0;
                tt_n[i]   = 1'b0;
            end else begin
                case (mode_q[i])
                    MODE_TON: begin
                        if (!en[i]) begin
                            acc_n[i] = '0;
                            dn_n[i]  = 1'b0;
                            tt_n[i]  = 1'b0;
                        end else begin
                            acc_n[i] = acc_step[i];
                            dn_n[i]  = (acc_step[i] >= pre_cur[i]);
                            tt_n[i]  = !(acc_step[i] >= pre_cur[i]);
                        end
                    end
                    MODE_TOF: begin
                        if (en[i]) begin
                            acc_n[i] = '0;
                            dn_n[i]  = 1'b1;
                            tt_n[i]  = 1'b0;
                        end else if (DN[i]) begin
                            // Off-delay runs only while still done; expiry drops DN and TT together.
                            acc_n[i] = acc_step[i];
                            dn_n[i]  = (acc_step[i] < pre_cur[i]);
                            tt_n[i]  = (acc_step[i] < pre_cur[i]);
                        end else begin
                            dn_n[i] = 1'b0;
                            tt_n[i] = 1'b0;
                        end
                    end
                    MODE_RTO: begin
                        if (en[i]) begin
                            acc_n[i] = acc_step[i];
                            dn_n[i]  = (acc_step[i] >= pre_cur[i]);
                            tt_n[i]  = !(acc_step[i] >= pre_cur[i]);
                        end else begin
                            dn_n[i] = (acc_cur[i] >= pre_cur[i]);
                            tt_n[i] = 1'b0;
                        end
                    end
                    MODE_TP: begin
                        if (TT[i]) begin
                            // Pulse in progress: en edges are ignored until expiry.
                            acc_n[i] = acc_step[i];
                            dn_n[i]  = !(acc_step[i] >= pre_cur[i]);
                            tt_n[i]  = !(acc_step[i] >= pre_cur[i]);
                        end else if (en[i] && !en_d[i] && (pre_cur[i] != '0)) begin
                            acc_n[i] = '0;
                            dn_n[i]  = 1'b1;
                            tt_n[i]  = 1'b1;
                        end else begin
                            dn_n[i] = 1'b0;
                            tt_n[i] = 1'b0;
                        end
                    end
                    default: begin
                        acc_n[i] = acc_cur[i];
                    end
                endcase
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ACC  <= '0;
            DN   <= '0;
            TT   <= '0;
            en_d <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mode_q[i] <= MODE_TON;
            end
        end else begin
            DN   <= dn_n;
            TT   <= tt_n;
            en_d <= en;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                ACC[i*ACC_W +: ACC_W] <= acc_n[i];
                mode_q[i]             <= mode_n[i];
            end
        end
    end

endmodule
